// File: rtl/latch_q_debouncer.sv
// latch_q_debouncer: brings an asynchronous latch level into the clk domain,
// debounces it with a stable-level FSM and reports a clean level, one-cycle
// rise/fall pulses and a saturating count of accepted rising events.
module latch_q_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,  // samples needed to accept a level (>= 2)
  parameter int unsigned CNT_W         = 8,  // width of event_count
  parameter int unsigned CW            = 3   // stability counter width, must hold STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             latch_q,
  input  logic             cnt_clr,
  output logic             q_clean,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count
);

  // Debounce states: settled low/high plus the two qualification states.
  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CW-1:0]    LAST_CNT = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Synchronizer flops; only r_s2 is allowed to feed logic.
  logic r_s1;
  logic r_s2;

  // FSM state and stability counter.
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Registered outputs and their next values.
  logic             r_q_clean;
  logic             r_rise_pulse;
  logic             r_fall_pulse;
  logic [CNT_W-1:0] r_event_count;
  logic             w_q_clean_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Current sample has been stable for the required number of cycles.
  logic w_cnt_last;
  assign w_cnt_last = (r_cnt == LAST_CNT);

  // Two-flop synchronizer for the asynchronous latch level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= latch_q;
      r_s2 <= r_s1;
    end
  end

  // State register: FSM state and stability counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: qualify each level change for STABLE_CYCLES samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_LOW: begin
        if (r_s2) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = CW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (!r_s2) begin
          // A glitch shorter than the window returns to LOW silently.
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      ST_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = CW'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (r_s2) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: level and pulse change only on an accepted transition.
  always_comb begin
    w_q_clean_nxt = r_q_clean;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    case (r_state)
      ST_WAIT_HIGH: begin
        if (r_s2 && w_cnt_last) begin
          w_q_clean_nxt = 1'b1;
          w_rise_nxt    = 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (!r_s2 && w_cnt_last) begin
          w_q_clean_nxt = 1'b0;
          w_fall_nxt    = 1'b1;
        end
      end
      default: begin
        w_q_clean_nxt = r_q_clean;
      end
    endcase
  end

  // Output registers: clean level and single-cycle edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_clean    <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_q_clean    <= w_q_clean_nxt;
      r_rise_pulse <= w_rise_nxt;
      r_fall_pulse <= w_fall_nxt;
    end
  end

  // Saturating rising-event counter; a clear drops any coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event_count <= '0;
    end else if (cnt_clr) begin
      r_event_count <= '0;
    end else if (r_rise_pulse && (r_event_count != CNT_MAX)) begin
      r_event_count <= r_event_count + CNT_W'(1);
    end
  end

  assign q_clean     = r_q_clean;
  assign rise_pulse  = r_rise_pulse;
  assign fall_pulse  = r_fall_pulse;
  assign event_count = r_event_count;

endmodule

// File: tb/tb_latch_q_debouncer.sv
// Scoreboard bench for latch_q_debouncer: stimulus queues expected pulses,
// a monitor pops and compares whenever a rise or fall pulse appears.
module tb_latch_q_debouncer;

  localparam int unsigned STABLE = 4;
  localparam int unsigned CNTW   = 2;
  localparam int unsigned CWID   = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            latch_q;
  logic            cnt_clr;
  logic            q_clean;
  logic            rise_pulse;
  logic            fall_pulse;
  logic [CNTW-1:0] event_count;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit is_rise;
    int edge_no;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  latch_q_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CNTW),
    .CW           (CWID)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .latch_q    (latch_q),
    .cnt_clr    (cnt_clr),
    .q_clean    (q_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  // Edge number: after posedge N, cyc == N when sampled on the next negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new level held long enough to be accepted; queue the expected pulse.
  task automatic go_level(input bit lvl, input int cnt_during);
    latch_q = lvl;
    sb.push_back('{lvl, cyc + int'(STABLE) + 2, cnt_during});
    ticks(int'(STABLE) + 4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_q_clean"}, 32'(q_clean), 0);
    chk({tag, "_rise"}, 32'(rise_pulse), 0);
    chk({tag, "_fall"}, 32'(fall_pulse), 0);
    chk({tag, "_count"}, 32'(event_count), 0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rise_pulse || fall_pulse) begin
        chk("pulse_exclusive", 32'(rise_pulse & fall_pulse), 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, expected no pulse",
                   rise_pulse, fall_pulse, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind", 32'(rise_pulse), 32'(mon_e.is_rise));
          chk("pulse_edge", 32'(cyc), 32'(mon_e.edge_no));
          chk("pulse_q_clean", 32'(q_clean), 32'(mon_e.is_rise));
          chk("pulse_count", 32'(event_count), 32'(mon_e.cnt));
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b0;
    latch_q = 1'b0;
    cnt_clr = 1'b0;

    // T1: reset held while latch_q toggles, then released.
    ticks(1);
    latch_q = 1'b1; ticks(2);
    latch_q = 1'b0; ticks(1);
    latch_q = 1'b1; ticks(1);
    chk_idle("t1_in_reset");
    latch_q = 1'b0;
    reset_n = 1'b1;
    ticks(int'(STABLE) + 4);
    chk_idle("t1_after_release");

    // T2: clean rise, pulse on edge STABLE+2, count 1 afterwards.
    go_level(1'b1, 0);
    chk("t2_q_clean", 32'(q_clean), 1);
    chk("t2_count", 32'(event_count), 1);

    // Low glitch of STABLE-1 edges while HIGH is rejected.
    latch_q = 1'b0; ticks(int'(STABLE) - 1);
    latch_q = 1'b1; ticks(int'(STABLE) + 4);
    chk("glitch_low_q_clean", 32'(q_clean), 1);
    chk("glitch_low_count", 32'(event_count), 1);

    // T4: clean fall.
    go_level(1'b0, 1);
    chk("t4_q_clean", 32'(q_clean), 0);
    chk("t4_count", 32'(event_count), 1);

    // T3: high glitch of 3 edges from LOW is rejected.
    latch_q = 1'b1; ticks(3);
    latch_q = 1'b0; ticks(int'(STABLE) + 4);
    chk("t3_q_clean", 32'(q_clean), 0);
    chk("t3_count", 32'(event_count), 1);

    // Fast toggling with runs of 1..3 samples never changes q_clean.
    for (int i = 0; i < 12; i++) begin
      latch_q = ~latch_q;
      ticks(1 + (i % 3));
    end
    ticks(int'(STABLE) + 4);
    chk("toggle_q_clean", 32'(q_clean), 0);
    chk("toggle_count", 32'(event_count), 1);

    // T5: saturation at 2^CNTW-1 = 3.
    go_level(1'b1, 1);
    go_level(1'b0, 2);
    go_level(1'b1, 2);
    go_level(1'b0, 3);
    go_level(1'b1, 3);
    chk("t5_saturated", 32'(event_count), 3);
    go_level(1'b0, 3);

    // Fifth rise with cnt_clr during the pulse cycle: clear wins.
    latch_q = 1'b1;
    sb.push_back('{1'b1, cyc + int'(STABLE) + 2, 3});
    ticks(int'(STABLE) + 2);
    cnt_clr = 1'b1;
    ticks(1);
    cnt_clr = 1'b0;
    chk("t5_cleared", 32'(event_count), 0);
    ticks(3);
    chk("t5_clear_hold", 32'(event_count), 0);
    chk("t5_q_clean", 32'(q_clean), 1);

    // T6: reset during WAIT_HIGH discards progress.
    go_level(1'b0, 0);
    latch_q = 1'b1;
    ticks(4);
    reset_n = 1'b0;
    #1;
    chk_idle("t6_reset");
    ticks(2);
    reset_n = 1'b1;
    sb.push_back('{1'b1, cyc + int'(STABLE) + 2, 0});
    ticks(int'(STABLE) + 4);
    chk("t6_q_clean", 32'(q_clean), 1);
    chk("t6_count", 32'(event_count), 1);

    // Asynchronous reset between clock edges clears outputs at once.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_q_clean", 32'(q_clean), 0);
    chk("async_count", 32'(event_count), 0);
    ticks(2);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
